// File: rtl/tetris_step_ctrl.sv
// Game sequencer: turns frame ticks and key edges into one-at-a-time move requests,
// then drives commit / spawn / lock / line-clear handshakes and keeps the score.
module tetris_step_ctrl #(
  parameter int unsigned DROP_PERIOD = 30,
  parameter logic [7:0]  KEY_START   = 8'h16,
  parameter logic [7:0]  KEY_LEFT    = 8'h04,
  parameter logic [7:0]  KEY_RIGHT   = 8'h07,
  parameter logic [7:0]  KEY_ROT     = 8'h1A
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  output logic        move_req,
  output logic [1:0]  move_dx,
  output logic        move_dy,
  output logic        move_rot,
  input  logic        move_ack,
  input  logic        move_ok,
  output logic        commit,
  output logic        spawn,
  input  logic        spawn_ack,
  input  logic        spawn_blocked,
  output logic        lock,
  input  logic        lock_ack,
  output logic        clear_start,
  input  logic        clear_done,
  input  logic [2:0]  lines_cleared,
  output logic [15:0] score,
  output logic        game_active,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FALL_WAIT, S_CHECK, S_LOCK, S_CLEAR, S_GAMEOVER
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(DROP_PERIOD - 1);

  state_t      state;
  logic [5:0]  grav_cnt;
  logic        pend_grav;
  logic [7:0]  key_prev;
  logic        cand_grav;   // outstanding candidate is a gravity step

  logic        key_new;
  logic        move_key;
  logic        grav_wrap;
  logic [3:0]  points;
  logic [16:0] score_sum;
  logic [15:0] score_next;

  assign key_new   = (keycode != key_prev) && (keycode != 8'h00);
  assign move_key  = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) || (keycode == KEY_ROT);
  assign grav_wrap = (grav_cnt == CNT_LAST);

  // NOTE: combinational blocks assign a default first so no path leaves a latch.
  always_comb begin
    points = 4'd0;
    case (lines_cleared)
      3'd0:    points = 4'd0;
      3'd1:    points = 4'd1;
      3'd2:    points = 4'd3;
      3'd3:    points = 4'd5;
      default: points = 4'd8;
    endcase
  end

  assign score_sum  = {1'b0, score} + 17'(points);
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // NOTE: state uses non-blocking assignments; where two assignments to the same
  // register occur in one cycle, the later one in this block takes effect.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      grav_cnt    <= '0;
      pend_grav   <= 1'b0;
      key_prev    <= '0;
      cand_grav   <= 1'b0;
      move_req    <= 1'b0;
      move_dx     <= 2'b00;
      move_dy     <= 1'b0;
      move_rot    <= 1'b0;
      commit      <= 1'b0;
      spawn       <= 1'b0;
      lock        <= 1'b0;
      clear_start <= 1'b0;
      score       <= '0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      key_prev    <= keycode;
      commit      <= 1'b0;
      spawn       <= 1'b0;
      clear_start <= 1'b0;

      // Gravity timebase keeps running while a candidate is being checked.
      if (state == S_FALL_WAIT || state == S_CHECK) begin
        if (grav_wrap) begin
          grav_cnt  <= '0;
          pend_grav <= 1'b1;
        end else begin
          grav_cnt  <= grav_cnt + 6'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (key_new && keycode == KEY_START) begin
            state <= S_SPAWN;
            spawn <= 1'b1;
            score <= '0;
          end
        end

        S_SPAWN: begin
          if (spawn_ack) begin
            if (spawn_blocked) begin
              state     <= S_GAMEOVER;
              game_over <= 1'b1;
            end else begin
              state       <= S_FALL_WAIT;
              game_active <= 1'b1;
              grav_cnt    <= '0;
              pend_grav   <= 1'b0;
            end
          end
        end

        S_FALL_WAIT: begin
          if (key_new && move_key) begin
            state     <= S_CHECK;
            move_req  <= 1'b1;
            move_dx   <= (keycode == KEY_LEFT)  ? 2'b11 :
                         (keycode == KEY_RIGHT) ? 2'b01 : 2'b00;
            move_dy   <= 1'b0;
            move_rot  <= (keycode == KEY_ROT);
            cand_grav <= 1'b0;
          end else if (pend_grav) begin
            state     <= S_CHECK;
            move_req  <= 1'b1;
            move_dx   <= 2'b00;
            move_dy   <= 1'b1;
            move_rot  <= 1'b0;
            cand_grav <= 1'b1;
          end
        end

        S_CHECK: begin
          if (move_ack) begin
            move_req <= 1'b0;
            move_dx  <= 2'b00;
            move_dy  <= 1'b0;
            move_rot <= 1'b0;
            if (move_ok) begin
              commit <= 1'b1;
              state  <= S_FALL_WAIT;
              // A wrap landing on this ack is a fresh gravity step and must survive.
              if (cand_grav && !grav_wrap) pend_grav <= 1'b0;
            end else if (cand_grav) begin
              state     <= S_LOCK;
              lock      <= 1'b1;
              pend_grav <= 1'b0;
            end else begin
              state <= S_FALL_WAIT;
            end
          end
        end

        S_LOCK: begin
          if (lock_ack) begin
            lock        <= 1'b0;
            clear_start <= 1'b1;
            state       <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clear_done) begin
            score       <= score_next;
            state       <= S_SPAWN;
            spawn       <= 1'b1;
            game_active <= 1'b0;
          end
        end

        S_GAMEOVER: begin
          if (key_new && keycode == KEY_START) begin
            state     <= S_SPAWN;
            spawn     <= 1'b1;
            score     <= '0;
            game_over <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_step_ctrl.sv
// Scoreboard bench for tetris_step_ctrl: stimulus pushes expected events, a monitor
// pops and compares them as the DUT raises requests and pulses.
`timescale 1ns/1ps
module tb_tetris_step_ctrl;

  localparam logic [7:0] KEY_START = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
  localparam logic [7:0] KEY_OTHER = 8'h2C;
  localparam int         PERIOD    = 30;

  typedef enum int {EV_MOVE, EV_COMMIT, EV_SPAWN, EV_LOCK, EV_CLEAR} ev_e;
  typedef struct {
    ev_e         kind;
    logic [1:0]  dx;
    logic        dy;
    logic        rot;
    logic [15:0] score;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  keycode;
  logic        move_req;
  logic [1:0]  move_dx;
  logic        move_dy;
  logic        move_rot;
  logic        move_ack;
  logic        move_ok;
  logic        commit;
  logic        spawn;
  logic        spawn_ack;
  logic        spawn_blocked;
  logic        lock;
  logic        lock_ack;
  logic        clear_start;
  logic        clear_done;
  logic [2:0]  lines_cleared;
  logic [15:0] score;
  logic        game_active;
  logic        game_over;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  // Environment / model state
  logic next_ok   = 1'b1;
  logic resp_auto = 1'b1;
  int   n_acks    = 0;
  int   late_req  = 0;
  int   late_done = 0;
  int   resp_dly;
  int   model_score = 0;

  // Monitor bookkeeping
  logic mreq_q = 1'b0;
  logic lock_q = 1'b0;
  logic grav_valid = 1'b0;
  int   last_grav_cyc = 0;
  int   last_commit_cyc = 0;
  int   skip_period = 0;
  logic chk_after_commit = 1'b0;

  tetris_step_ctrl dut (
    .frame_clk     (clk),
    .Reset_n       (rst_n),
    .keycode       (keycode),
    .move_req      (move_req),
    .move_dx       (move_dx),
    .move_dy       (move_dy),
    .move_rot      (move_rot),
    .move_ack      (move_ack),
    .move_ok       (move_ok),
    .commit        (commit),
    .spawn         (spawn),
    .spawn_ack     (spawn_ack),
    .spawn_blocked (spawn_blocked),
    .lock          (lock),
    .lock_ack      (lock_ack),
    .clear_start   (clear_start),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared),
    .score         (score),
    .game_active   (game_active),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_e k, input logic [1:0] dx, input logic dy,
                         input logic rot, input logic [15:0] sc);
    exp_t e;
    e.kind = k; e.dx = dx; e.dy = dy; e.rot = rot; e.score = sc;
    exp_q.push_back(e);
  endtask

  // A legal candidate is always followed by a commit; an illegal gravity step locks.
  task automatic push_grav(input logic ok);
    push_ev(EV_MOVE, 2'b00, 1'b1, 1'b0, 16'h0);
    if (ok) push_ev(EV_COMMIT, 2'b00, 1'b0, 1'b0, 16'h0);
    else    push_ev(EV_LOCK,   2'b00, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic push_key(input logic [7:0] code, input logic ok);
    logic [1:0] dx;
    dx = 2'b00;
    if (code == KEY_LEFT)  dx = 2'b11;
    if (code == KEY_RIGHT) dx = 2'b01;
    push_ev(EV_MOVE, dx, 1'b0, code == KEY_ROT, 16'h0);
    if (ok) push_ev(EV_COMMIT, 2'b00, 1'b0, 1'b0, 16'h0);
  endtask

  function automatic int score_add(input int s, input int lines);
    int tbl[5] = '{0, 1, 3, 5, 8};
    int r;
    r = s + tbl[(lines > 4) ? 4 : lines];
    return (r > 65535) ? 65535 : r;
  endfunction

  task automatic observe(input ev_e k);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %s, expected none (cycle %0d)", k.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    if (k == EV_MOVE)  check("move_fields", {move_dx, move_dy, move_rot}, {e.dx, e.dy, e.rot});
    if (k == EV_SPAWN) check("spawn_score", score, e.score);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mreq_q     = 1'b0;
      lock_q     = 1'b0;
      grav_valid = 1'b0;
    end else begin
      if (move_req && !mreq_q) begin
        observe(EV_MOVE);
        if (move_dy) begin
          if (chk_after_commit) begin
            check("grav_after_key_commit", cyc - last_commit_cyc, 1);
            chk_after_commit = 1'b0;
          end
          if (grav_valid) begin
            if (skip_period > 0) skip_period--;
            else check("grav_period", cyc - last_grav_cyc, PERIOD);
          end
          grav_valid    = 1'b1;
          last_grav_cyc = cyc;
        end
      end
      if (commit) begin
        observe(EV_COMMIT);
        last_commit_cyc = cyc;
      end
      if (spawn) begin
        observe(EV_SPAWN);
        grav_valid = 1'b0;
      end
      if (lock && !lock_q) observe(EV_LOCK);
      if (clear_start) observe(EV_CLEAR);
      mreq_q = move_req;
      lock_q = lock;
    end
  end

  // Collision-checker stand-in: acks each request after 1..3 cycles with next_ok.
  initial begin
    move_ack = 1'b0;
    move_ok  = 1'b0;
    forever begin
      @(negedge clk);
      if (late_req != late_done) begin
        move_ack = 1'b1;
        move_ok  = 1'b1;
        @(negedge clk);
        move_ack  = 1'b0;
        move_ok   = 1'b0;
        late_done = late_req;
      end else if (rst_n && move_req && resp_auto) begin
        resp_dly = $urandom_range(1, 3);
        repeat (resp_dly - 1) @(negedge clk);
        move_ack = 1'b1;
        move_ok  = next_ok;
        @(negedge clk);
        move_ack = 1'b0;
        move_ok  = 1'b0;
        n_acks++;
      end
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_ack(input int a0, input int budget, input string name);
    int i;
    i = 0;
    while (n_acks == a0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, n_acks != a0, 1);
  endtask

  task automatic pulse_spawn_ack(input logic blocked);
    spawn_ack     = 1'b1;
    spawn_blocked = blocked;
    @(negedge clk);
    spawn_ack     = 1'b0;
    spawn_blocked = 1'b0;
  endtask

  initial begin
    logic [7:0] codes[5];
    int cnt;
    int lines;
    int a0;
    int target;

    codes = '{KEY_LEFT, KEY_RIGHT, KEY_ROT, KEY_OTHER, KEY_START};
    rst_n = 1'b0; keycode = 8'h00; spawn_ack = 1'b0; spawn_blocked = 1'b0;
    lock_ack = 1'b0; clear_done = 1'b0; lines_cleared = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {move_req, move_dx, move_dy, move_rot, commit, spawn, lock,
                            clear_start, score, game_active, game_over}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: start key -> spawn one cycle later, active after spawn_ack
    push_ev(EV_SPAWN, 2'b00, 1'b0, 1'b0, 16'h0);
    keycode = KEY_START;
    @(negedge clk);
    check("t1_spawn_latency", spawn, 1);
    keycode = 8'h00;
    @(negedge clk);
    check("t1_spawn_pulse_width", spawn, 0);
    check("t1_inactive_in_spawn", game_active, 0);
    pulse_spawn_ack(1'b0);
    check("t1_active_after_ack", game_active, 1);

    // T2: gravity only; first request 31 edges after the spawn ack, then every 30
    next_ok = 1'b1;
    repeat (3) push_grav(1'b1);
    cnt = 1;
    while (!move_req && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("t2_first_grav_latency", cnt, 32);
    wait_drain(200, "t2_drain");

    // Random key moves placed between gravity steps, random verdicts
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] code;
        logic       ok;
        int         hold;
        if (cyc - last_grav_cyc > 18) break;
        code = codes[$urandom_range(0, 4)];
        ok   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 3);
        next_ok = ok;
        a0 = n_acks;
        if (code == KEY_LEFT || code == KEY_RIGHT || code == KEY_ROT) push_key(code, ok);
        keycode = code;
        repeat (hold) @(negedge clk);
        keycode = 8'h00;
        if (code == KEY_LEFT || code == KEY_RIGHT || code == KEY_ROT) begin
          wait_ack(a0, 20, "rand_key_ack");
          wait_drain(20, "rand_key_drain");
        end
        @(negedge clk);
      end
      next_ok = 1'b1;
      push_grav(1'b1);
      wait_drain(60, "rand_grav_drain");
    end

    // T3: held left key -> one request only; illegal -> no commit, still playing
    next_ok = 1'b0;
    a0 = n_acks;
    push_key(KEY_LEFT, 1'b0);
    keycode = KEY_LEFT;
    @(negedge clk);
    check("t3_key_to_req_latency", move_req, 1);
    wait_ack(a0, 20, "t3_key_ack");
    next_ok = 1'b1;
    repeat (4) push_grav(1'b1);
    wait_drain(200, "t3_drain");
    keycode = 8'h00;
    check("t3_still_active", game_active, 1);

    // T4: key edge on the wrap edge -> key first, gravity right after its commit
    skip_period = 2;
    chk_after_commit = 1'b1;
    next_ok = 1'b1;
    push_key(KEY_ROT, 1'b1);
    push_grav(1'b1);
    target = last_grav_cyc + PERIOD - 2;
    cnt = 0;
    while (cyc < target && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_align", cyc, target);
    keycode = KEY_ROT;
    @(negedge clk);
    keycode = 8'h00;
    wait_drain(100, "t4_drain");

    // T5: illegal gravity -> lock, clear, scoring; then saturation; last spawn blocked
    for (int p = 0; p < 4; p++) begin
      if (p == 2) begin
        force dut.score = 16'hFFFC;
        @(negedge clk);
        release dut.score;
        model_score = 16'hFFFC;
      end
      lines = (p == 0 || p == 2) ? 4 : (p == 3) ? 1 : $urandom_range(0, 7);
      next_ok = 1'b0;
      push_grav(1'b0);
      wait_drain(100, "t5_lock_drain");
      repeat (3) @(negedge clk);
      check("t5_lock_held", {lock, clear_start}, 2'b10);
      push_ev(EV_CLEAR, 2'b00, 1'b0, 1'b0, 16'h0);
      lock_ack = 1'b1;
      @(negedge clk);
      lock_ack = 1'b0;
      check("t5_lock_released", lock, 0);
      wait_drain(5, "t5_clear_drain");
      model_score = score_add(model_score, lines);
      push_ev(EV_SPAWN, 2'b00, 1'b0, 1'b0, 16'(model_score));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      clear_done = 1'b1;
      lines_cleared = 3'(lines);
      @(negedge clk);
      clear_done = 1'b0;
      lines_cleared = 3'd0;
      wait_drain(5, "t5_spawn_drain");
      check("t5_score", score, model_score);
      pulse_spawn_ack(p == 3);
      if (p < 3) check("t5_active_again", game_active, 1);
    end

    // T6: game over holds score; move keys ignored; start restarts with score 0
    check("t6_game_over", {game_over, game_active}, 2'b10);
    keycode = KEY_LEFT;
    repeat (2) @(negedge clk);
    keycode = 8'h00;
    @(negedge clk);
    check("t6_score_held", score, model_score);
    check("t6_still_over", game_over, 1);
    model_score = 0;
    push_ev(EV_SPAWN, 2'b00, 1'b0, 1'b0, 16'h0);
    keycode = KEY_START;
    @(negedge clk);
    keycode = 8'h00;
    wait_drain(5, "t6_restart_drain");
    check("t6_over_cleared", game_over, 0);
    @(negedge clk);
    pulse_spawn_ack(1'b0);
    check("t6_active", game_active, 1);

    // Reset in the middle of a gravity handshake, then a late ack
    resp_auto = 1'b0;
    exp_q.delete();
    push_ev(EV_MOVE, 2'b00, 1'b1, 1'b0, 16'h0);
    wait_drain(60, "t6_req_drain");
    check("t6_req_pending", move_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", {move_req, move_dx, move_dy, move_rot, commit, spawn, lock,
                             clear_start, score, game_active, game_over}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_req++;
    repeat (4) @(negedge clk);
    check("t6_late_ack_ignored", {move_req, commit, spawn, lock, clear_start,
                                  game_active, game_over}, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
